matrix_readout: RTL and testbench
=================================

MATRIX_READOUT -- requirements
Module: matrix_readout

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 7, giving the number of clk cycles from Start to result capture; the legal range SHALL be 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: request to time, capture and stream one 3x3 result.
REQ-005 The block SHALL have ports In00, In01, In02, In10, In11, In12, In20, In21, In22, each input, 8 bits: the result matrix elements, InRC meaning row R, column C.
REQ-006 The block SHALL have port Out_data, output, 8 bits: the current streamed element.
REQ-007 The block SHALL have port Out_index, output, 4 bits: the row-major index (0..8) of Out_data.
REQ-008 The block SHALL have port Out_valid, output, 1 bit: Out_data is offered.
REQ-009 The block SHALL have port Out_ready, input, 1 bit: the consumer accepts Out_data.
REQ-010 The block SHALL have port Out_last, output, 1 bit: high while Out_valid is high and Out_index equals 8.
REQ-011 The block SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement three states: IDLE, WAIT and STREAM.
REQ-013 In IDLE, when Start=1 at a rising edge, the block SHALL clear the wait counter to 0 and enter WAIT.
REQ-014 In WAIT, the counter SHALL increment by 1 per cycle; at the edge where the counter equals WAIT_CYCLES-1, all nine In inputs SHALL be copied into a 9x8-bit buffer, the index SHALL be set to 0, and the state SHALL become STREAM.
REQ-015 The capture SHALL therefore occur exactly WAIT_CYCLES rising edges after the edge that sampled Start; with the default, this is 7 edges.
REQ-016 Out_valid SHALL be 1 exactly when the state is STREAM.
REQ-017 Out_data SHALL equal buffer[Out_index], with row-major order 00,01,02,10,11,12,20,21,22.
REQ-018 A transfer SHALL occur at a rising edge where Out_valid=1 and Out_ready=1.
REQ-019 On a transfer with index below 8, the index SHALL increment by 1.
REQ-020 On a transfer with index equal to 8, the block SHALL return to IDLE and set the index to 0.
REQ-021 While Out_valid=1 and Out_ready=0, Out_data and Out_index SHALL hold their values; there is no timeout.
REQ-022 Start SHALL be ignored in WAIT and STREAM, including the cycle of the final transfer; it SHALL NOT be queued.
REQ-023 The buffer SHALL change only at a capture edge; changes on the In ports after capture SHALL NOT affect streamed data.
REQ-024 Out_ready SHALL be ignored outside STREAM.
REQ-025 With Out_ready held at 1, the nine transfers SHALL occur on nine consecutive edges, and Busy SHALL fall in the cycle after the last transfer.
REQ-026 Elements SHALL be passed unmodified: no arithmetic, no truncation, no sign handling.
REQ-027 A Start in IDLE that coincides with a Reset edge SHALL be discarded.

Reset
REQ-028 When Reset=1 at a rising edge, the block SHALL set the state to IDLE, the counter to 0, the index to 0 and all buffer bytes to 0, regardless of current state.
REQ-029 After reset, the outputs SHALL be Out_valid=0, Out_last=0, Busy=0, Out_index=0 and Out_data=0.
REQ-030 Reset SHALL take priority over Start, Out_ready and the capture, including mid-WAIT and mid-STREAM.

Verification
REQ-031 Basic capture and stream: In00..In22=1..9, Start pulse, Out_ready=1 -> Out_valid rises 7 edges after Start; data 1..9 on 9 consecutive cycles; Out_last only with 9; Busy low afterward.
REQ-032 Backpressure: same stimulus, Out_ready=0 for 5 cycles at index 3 -> Out_data=4 and Out_index=3 held for those 5 cycles; the remaining sequence is unchanged.
REQ-033 Late input change: In inputs changed to 0xFF one cycle after capture -> the streamed data is still 1..9.
REQ-034 Start ignored: Start pulses during WAIT and during the final transfer -> exactly one 9-element stream, then IDLE.
REQ-035 Reset mid-stream: Reset asserted at index 4 -> next cycle Out_valid=0 and Busy=0; a new Start yields a fresh full stream starting at index 0.
REQ-036 Parameter: WAIT_CYCLES=1 and 255 -> capture 1 and 255 edges after Start respectively.

Source files
------------

// File: rtl/matrix_readout.sv
// matrix_readout: waits a fixed number of cycles after Start, snapshots a
// 3x3 matrix of bytes into an internal buffer, then streams the nine
// elements in row-major order over a valid/ready handshake.
module matrix_readout #(
    parameter int WAIT_CYCLES = 7
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] In00,
    input  logic [7:0] In01,
    input  logic [7:0] In02,
    input  logic [7:0] In10,
    input  logic [7:0] In11,
    input  logic [7:0] In12,
    input  logic [7:0] In20,
    input  logic [7:0] In21,
    input  logic [7:0] In22,
    output logic [7:0] Out_data,
    output logic [3:0] Out_index,
    output logic       Out_valid,
    input  logic       Out_ready,
    output logic       Out_last,
    output logic       Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    // The counter runs 0..WAIT_CYCLES-1, so the last value fits in 8 bits
    // for the whole legal range of 1..255.
    localparam logic [7:0] LAST_COUNT = 8'(WAIT_CYCLES - 1);
    localparam logic [3:0] LAST_INDEX = 4'd8;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_count;
    logic [7:0] next_wait_count;
    logic [3:0] index;
    logic [3:0] next_index;
    logic       capture;
    logic       transfer;

    logic [7:0] buffer   [0:8];
    logic [7:0] in_elems [0:8];

    // Gather the matrix inputs into row-major order so capture is a simple copy.
    always_comb begin
        in_elems[0] = In00;
        in_elems[1] = In01;
        in_elems[2] = In02;
        in_elems[3] = In10;
        in_elems[4] = In11;
        in_elems[5] = In12;
        in_elems[6] = In20;
        in_elems[7] = In21;
        in_elems[8] = In22;
    end

    // A handshake completes only while streaming; Out_ready is ignored elsewhere.
    assign transfer = (state == S_STREAM) && Out_ready;

    // Next-state logic: Start is only honoured in IDLE, so it is never queued.
    always_comb begin
        next_state      = state;
        next_wait_count = wait_count;
        next_index      = index;
        capture         = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    next_wait_count = '0;
                    next_state      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_count == LAST_COUNT) begin
                    capture    = 1'b1;
                    next_index = '0;
                    next_state = S_STREAM;
                end else begin
                    next_wait_count = wait_count + 8'd1;
                end
            end
            S_STREAM: begin
                if (transfer) begin
                    if (index == LAST_INDEX) begin
                        next_index = '0;
                        next_state = S_IDLE;
                    end else begin
                        next_index = index + 4'd1;
                    end
                end
            end
            default: begin
                next_state      = S_IDLE;
                next_wait_count = '0;
                next_index      = '0;
            end
        endcase
    end

    // Control registers; reset overrides every other activity.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            wait_count <= '0;
            index      <= '0;
        end else begin
            state      <= next_state;
            wait_count <= next_wait_count;
            index      <= next_index;
        end
    end

    // Snapshot buffer: written only on the capture edge so later input changes are invisible.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 9; i++) begin
                buffer[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < 9; i++) begin
                buffer[i] <= in_elems[i];
            end
        end
    end

    assign Out_valid = (state == S_STREAM);
    assign Out_index = index;
    assign Out_data  = buffer[index];
    assign Out_last  = Out_valid && (index == LAST_INDEX);
    assign Busy      = (state != S_IDLE);

endmodule

// File: tb/tb_matrix_readout.sv
// Scoreboard bench for matrix_readout: stimulus pushes expected elements,
// a negedge monitor compares whatever the DUT offers.
module tb_matrix_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset;
    logic       Start;
    logic       Out_ready;
    logic [7:0] In00, In01, In02, In10, In11, In12, In20, In21, In22;

    logic [7:0] Out_data;
    logic [3:0] Out_index;
    logic       Out_valid;
    logic       Out_last;
    logic       Busy;

    logic [7:0] data1, data255;
    logic [3:0] index1, index255;
    logic       valid1, valid255;
    logic       last1, last255;
    logic       busy1, busy255;

    matrix_readout dut (
        .clk(clk), .Reset(Reset), .Start(Start),
        .In00(In00), .In01(In01), .In02(In02),
        .In10(In10), .In11(In11), .In12(In12),
        .In20(In20), .In21(In21), .In22(In22),
        .Out_data(Out_data), .Out_index(Out_index), .Out_valid(Out_valid),
        .Out_ready(Out_ready), .Out_last(Out_last), .Busy(Busy)
    );

    matrix_readout #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .Reset(Reset), .Start(Start),
        .In00(In00), .In01(In01), .In02(In02),
        .In10(In10), .In11(In11), .In12(In12),
        .In20(In20), .In21(In21), .In22(In22),
        .Out_data(data1), .Out_index(index1), .Out_valid(valid1),
        .Out_ready(Out_ready), .Out_last(last1), .Busy(busy1)
    );

    matrix_readout #(.WAIT_CYCLES(255)) dut255 (
        .clk(clk), .Reset(Reset), .Start(Start),
        .In00(In00), .In01(In01), .In02(In02),
        .In10(In10), .In11(In11), .In12(In12),
        .In20(In20), .In21(In21), .In22(In22),
        .Out_data(data255), .Out_index(index255), .Out_valid(valid255),
        .Out_ready(Out_ready), .Out_last(last255), .Busy(busy255)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] index;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   checks      = 0;
    int   failures    = 0;
    logic expect_idle = 1'b0;

    // Element k of a matrix word is byte k, row-major (k=0 is In00, k=8 is In22).
    localparam logic [71:0] MAT_SEQ = 72'h09_08_07_06_05_04_03_02_01;
    localparam logic [71:0] MAT_ALT = 72'h5A_FF_80_7F_00_33_22_11_A5;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive a matrix, record its nine expected elements, and pulse Start once.
    task automatic applyStimulus(input logic [71:0] m);
        exp_t e;
        In00 = m[7:0];   In01 = m[15:8];  In02 = m[23:16];
        In10 = m[31:24]; In11 = m[39:32]; In12 = m[47:40];
        In20 = m[55:48]; In21 = m[63:56]; In22 = m[71:64];
        for (int k = 0; k < 9; k++) begin
            e.data  = m[8*k +: 8];
            e.index = 4'(k);
            e.last  = (k == 8);
            sb_q.push_back(e);
        end
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!Out_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (Busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic waitIndex(input logic [3:0] target);
        int n;
        n = 0;
        while (!(Out_valid && Out_index == target) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reach_index", {28'd0, Out_index}, {28'd0, target});
    endtask

    // Monitor: compare every offered element against the queue head; pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (expect_idle) begin
            checkOutput("busy_after_last", {31'd0, Busy}, 32'd0);
            expect_idle = 1'b0;
        end
        if (Out_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid", {31'd0, Out_valid}, 32'd0);
            end else begin
                e = sb_q[0];
                checkOutput("out_data", {24'd0, Out_data}, {24'd0, e.data});
                checkOutput("out_index", {28'd0, Out_index}, {28'd0, e.index});
                checkOutput("out_last", {31'd0, Out_last}, {31'd0, e.last});
                if (Out_ready) begin
                    void'(sb_q.pop_front());
                    if (e.last) expect_idle = 1'b1;
                end
            end
        end else begin
            checkOutput("last_without_valid", {31'd0, Out_last}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int lat1;
        int lat255;

        Reset = 1'b1; Start = 1'b0; Out_ready = 1'b1;
        In00 = 0; In01 = 0; In02 = 0; In10 = 0; In11 = 0; In12 = 0; In20 = 0; In21 = 0; In22 = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'd0, Out_valid}, 32'd0);
        checkOutput("reset_last", {31'd0, Out_last}, 32'd0);
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset_index", {28'd0, Out_index}, 32'd0);
        checkOutput("reset_data", {24'd0, Out_data}, 32'd0);
        Reset = 1'b0;

        $display("[TB] basic capture and stream");
        applyStimulus(MAT_SEQ);
        waitValid(n);
        checkOutput("basic_latency", n, 7);
        waitIdle(n);
        checkOutput("basic_stream_len", n, 9);

        $display("[TB] backpressure at index 3");
        applyStimulus(MAT_SEQ);
        waitValid(n);
        checkOutput("bp_latency", n, 7);
        waitIndex(4'd3);
        Out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_hold_data", {24'd0, Out_data}, 32'd4);
            checkOutput("bp_hold_index", {28'd0, Out_index}, 32'd3);
        end
        Out_ready = 1'b1;
        waitIdle(n);
        checkOutput("bp_remaining_len", n, 6);

        $display("[TB] late input change");
        applyStimulus(MAT_SEQ);
        waitValid(n);
        In00 = 8'hFF; In01 = 8'hFF; In02 = 8'hFF; In10 = 8'hFF; In11 = 8'hFF;
        In12 = 8'hFF; In20 = 8'hFF; In21 = 8'hFF; In22 = 8'hFF;
        waitIdle(n);
        checkOutput("late_stream_len", n, 9);

        $display("[TB] start ignored while busy");
        applyStimulus(MAT_SEQ);
        repeat (3) @(posedge clk);
        #1;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        waitValid(n);
        checkOutput("ignore_latency_rest", n, 3);
        waitIndex(4'd8);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        checkOutput("ignore_final_busy", {31'd0, Busy}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("ignore_stays_idle", {31'd0, Busy}, 32'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(MAT_ALT);
        waitValid(n);
        waitIndex(4'd4);
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        sb_q.delete();
        checkOutput("rst_stream_valid", {31'd0, Out_valid}, 32'd0);
        checkOutput("rst_stream_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_stream_index", {28'd0, Out_index}, 32'd0);
        checkOutput("rst_stream_data", {24'd0, Out_data}, 32'd0);
        applyStimulus(MAT_ALT);
        waitValid(n);
        checkOutput("rst_new_latency", n, 7);
        waitIdle(n);
        checkOutput("rst_new_stream_len", n, 9);

        $display("[TB] reset mid-wait and reset with start");
        applyStimulus(MAT_SEQ);
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        sb_q.delete();
        checkOutput("rst_wait_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b1; Start = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0; Start = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_start_discard", {31'd0, Busy}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst_quiet_busy", {31'd0, Busy}, 32'd0);

        $display("[TB] wait-cycle parameter extremes");
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        applyStimulus(MAT_ALT);
        lat1 = 0;
        lat255 = 0;
        for (int k = 1; k <= 300 && lat255 == 0; k++) begin
            @(posedge clk); #1;
            if (valid1 && lat1 == 0) begin
                lat1 = k;
                checkOutput("w1_first_data", {24'd0, data1}, 32'hA5);
                checkOutput("w1_first_index", {28'd0, index1}, 32'd0);
                checkOutput("w1_first_last", {31'd0, last1}, 32'd0);
            end
            if (valid255 && lat255 == 0) begin
                lat255 = k;
                checkOutput("w255_first_data", {24'd0, data255}, 32'hA5);
                checkOutput("w255_first_index", {28'd0, index255}, 32'd0);
                checkOutput("w255_first_last", {31'd0, last255}, 32'd0);
            end
        end
        checkOutput("w1_latency", lat1, 1);
        checkOutput("w255_latency", lat255, 255);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("w1_idle", {31'd0, busy1}, 32'd0);
        checkOutput("w255_idle", {31'd0, busy255}, 32'd0);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
